// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control field and the forwarding selects.
// Decode and execute both import this package.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/signed slt, wrap-around, no flags.
// Unused encodings produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and the EX/MEM register feeding the memory stage.
module execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ResultSrcE0,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic            zero_e;

  // A flushed entry is all zeros, which decodes as a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      result_src_e  <= '0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_ext_e     <= '0;
      pc_e          <= '0;
      pc_plus4_e    <= '0;
      Rs1E          <= '0;
      Rs2E          <= '0;
      RdE           <= '0;
    end else begin
      reg_write_e   <= RegWriteD;
      mem_write_e   <= MemWriteD;
      jump_e        <= JumpD;
      branch_e      <= BranchD;
      alu_src_e     <= ALUSrcD;
      result_src_e  <= ResultSrcD;
      alu_control_e <= ALUControlD;
      rd1_e         <= RD1D;
      rd2_e         <= RD2D;
      imm_ext_e     <= ImmExtD;
      pc_e          <= PCD;
      pc_plus4_e    <= PCPlus4D;
      Rs1E          <= Rs1D;
      Rs2E          <= Rs2D;
      RdE           <= RdD;
    end
  end

  // Select 2'b11 falls back to the register-file operand.
  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a_e = ResultW;
      FWD_MEM: src_a_e = ALUResultM;
      default: src_a_e = rd1_e;
    endcase
    case (ForwardBE)
      FWD_WB:  write_data_e = ResultW;
      FWD_MEM: write_data_e = ALUResultM;
      default: write_data_e = rd2_e;
    endcase
  end

  assign src_b_e = alu_src_e ? imm_ext_e : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a_e),
    .SrcB       (src_b_e),
    .ALUControl (alu_control_e),
    .Result     (alu_result_e),
    .Zero       (zero_e)
  );

  assign PCTargetE   = pc_e + imm_ext_e;
  assign PCSrcE      = (branch_e & zero_e) | jump_e;
  assign ResultSrcE0 = result_src_e[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= reg_write_e;
      MemWriteM  <= mem_write_e;
      ResultSrcM <= result_src_e;
      RdM        <= RdE;
      ALUResultM <= alu_result_e;
      WriteDataM <= write_data_e;
      PCPlus4M   <= pc_plus4_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed steps plus random traffic,
// compared against a stage-level behavioural model.
module tb_execute_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD, ForwardAE, ForwardBE;
  logic [2:0] ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [4:0] Rs1E, Rs2E, RdE, RdM;
  logic ResultSrcE0, PCSrcE, RegWriteM, MemWriteM;
  logic [XLEN-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0] ResultSrcM;

  execute_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw, mw, jmp, br, alusrc;
    logic [1:0] rs;
    logic [2:0] ctl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rs1, rs2, rd;
  } ex_t;

  typedef struct {
    logic rw, mw;
    logic [1:0] rs;
    logic [4:0] rd;
    logic [31:0] alu, wd, pc4;
  } mem_t;

  localparam ex_t  EX_ZERO  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0};
  localparam mem_t MEM_ZERO = '{1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0};

  ex_t  me;
  mem_t mm;
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] rf);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return mm.alu;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ex_t cur_d();
    ex_t d;
    d.rw = RegWriteD; d.mw = MemWriteD; d.jmp = JumpD; d.br = BranchD;
    d.alusrc = ALUSrcD; d.rs = ResultSrcD; d.ctl = ALUControlD;
    d.rd1 = RD1D; d.rd2 = RD2D; d.imm = ImmExtD; d.pc = PCD; d.pc4 = PCPlus4D;
    d.rs1 = Rs1D; d.rs2 = Rs2D; d.rd = RdD;
    return d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] a, wd, b, r;
    a  = fwd(ForwardAE, me.rd1);
    wd = fwd(ForwardBE, me.rd2);
    b  = me.alusrc ? me.imm : wd;
    r  = alu_ref(me.ctl, a, b);
    chk({tag, ".Rs1E"}, Rs1E, me.rs1);
    chk({tag, ".Rs2E"}, Rs2E, me.rs2);
    chk({tag, ".RdE"}, RdE, me.rd);
    chk({tag, ".ResultSrcE0"}, ResultSrcE0, me.rs[0]);
    chk({tag, ".PCSrcE"}, PCSrcE, me.jmp | (me.br & (r == 32'd0)));
    chk({tag, ".PCTargetE"}, PCTargetE, me.pc + me.imm);
    chk({tag, ".RegWriteM"}, RegWriteM, mm.rw);
    chk({tag, ".MemWriteM"}, MemWriteM, mm.mw);
    chk({tag, ".ResultSrcM"}, ResultSrcM, mm.rs);
    chk({tag, ".RdM"}, RdM, mm.rd);
    chk({tag, ".ALUResultM"}, ALUResultM, mm.alu);
    chk({tag, ".WriteDataM"}, WriteDataM, mm.wd);
    chk({tag, ".PCPlus4M"}, PCPlus4M, mm.pc4);
  endtask

  // Check against the model, take one clock edge, advance the model.
  task automatic cycle(string tag);
    ex_t  ne;
    mem_t nm;
    logic [31:0] a, wd, b;
    #2;
    check_all(tag);
    a  = fwd(ForwardAE, me.rd1);
    wd = fwd(ForwardBE, me.rd2);
    b  = me.alusrc ? me.imm : wd;
    nm.rw = me.rw; nm.mw = me.mw; nm.rs = me.rs; nm.rd = me.rd;
    nm.alu = alu_ref(me.ctl, a, b); nm.wd = wd; nm.pc4 = me.pc4;
    ne = FlushE ? EX_ZERO : cur_d();
    if (!rst) begin ne = EX_ZERO; nm = MEM_ZERO; end
    @(posedge clk);
    me = ne;
    mm = nm;
    #1;
  endtask

  task automatic rand_d();
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    JumpD = 1'($urandom_range(0, 3) == 0); BranchD = 1'($urandom);
    ALUSrcD = 1'($urandom); ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    PCPlus4D = PCD + 32'd4;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
    if ($urandom_range(0, 3) == 0) RD2D = RD1D;
  endtask

  task automatic clr_d();
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 0; ALUControlD = 0; RD1D = 0; RD2D = 0; ImmExtD = 0;
    PCD = 0; PCPlus4D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
    FlushE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  logic [2:0]  ops[5]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
  logic [31:0] exps[5] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0};

  initial begin
    me = EX_ZERO; mm = MEM_ZERO;
    clr_d();
    rst = 1'b1;
    #1 rst = 1'b0;
    rand_d();
    ResultW = $urandom; ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    cycle("reset0");
    cycle("reset1");
    rst = 1'b1;
    cycle("release");
    chk("first_capture.RdE", RdE, RdD);
    cycle("after_release");

    foreach (ops[i]) begin
      clr_d();
      RD1D = 7; RD2D = 5; ALUControlD = ops[i];
      cycle("alu_cap");
      cycle("alu_mem");
      chk($sformatf("alu_op%0d", ops[i]), ALUResultM, exps[i]);
    end
    clr_d();
    RD1D = 32'hFFFF_FFFD; RD2D = 2; ALUControlD = 3'b101;
    cycle("slt_cap"); cycle("slt_mem");
    chk("slt_neg", ALUResultM, 32'd1);

    clr_d();
    BranchD = 1; ALUControlD = 3'b001; RD1D = 9; RD2D = 9; PCD = 32'h100; ImmExtD = 32'h20;
    cycle("beq_cap");
    chk("beq_taken", PCSrcE, 1'b1);
    chk("beq_target", PCTargetE, 32'h120);
    RD2D = 8;
    cycle("bne_cap");
    chk("beq_not_taken", PCSrcE, 1'b0);
    JumpD = 1;
    cycle("jmp_cap");
    chk("jump_taken", PCSrcE, 1'b1);
    FlushE = 1;
    #1 chk("flush_keeps_branch", PCSrcE, 1'b1);
    cycle("flush_jmp");
    chk("flush_bubble", PCSrcE, 1'b0);

    clr_d();
    RD1D = 32'h40;
    cycle("fwd_prod");
    RD1D = $urandom; RD2D = $urandom;
    cycle("fwd_cons");
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h4;
    chk("fwd_mem_src", ALUResultM, 32'h40);
    cycle("fwd_exec");
    chk("fwd_result", ALUResultM, 32'h44);
    chk("fwd_wdata", WriteDataM, 32'h4);
    clr_d();
    RD1D = 32'h10; RD2D = 32'h3;
    cycle("fwd11_cap");
    ForwardAE = 2'b11; ResultW = $urandom;
    cycle("fwd11_exec");
    chk("fwd11_rf", ALUResultM, 32'h13);

    clr_d();
    RegWriteD = 1; MemWriteD = 1; JumpD = 1; RdD = 5'd7; FlushE = 1;
    cycle("flush_cap");
    chk("flush_pcsrc", PCSrcE, 1'b0);
    chk("flush_rd", RdE, 5'd0);
    FlushE = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0;
    cycle("flush_mem");
    chk("flush_regwrite_m", RegWriteM, 1'b0);
    chk("flush_memwrite_m", MemWriteM, 1'b0);

    clr_d();
    RD1D = 32'hFFFF_FFFF; RD2D = 1; BranchD = 1;
    cycle("wrap_cap");
    chk("wrap_zero", PCSrcE, 1'b1);
    BranchD = 0; RD1D = 0; RD2D = 1; ALUControlD = 3'b001;
    cycle("wrap_mem");
    chk("wrap_add", ALUResultM, 32'd0);
    cycle("sub_mem");
    chk("wrap_sub", ALUResultM, 32'hFFFF_FFFF);

    for (int k = 0; k < 300; k++) begin
      rand_d();
      FlushE = 1'($urandom_range(0, 7) == 0);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
      if (k == 150) begin
        rst = 1'b0;
        #1;
        me = EX_ZERO; mm = MEM_ZERO;
        check_all("async_reset");
      end
      if (k == 152) rst = 1'b1;
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RISC-V pipeline. It holds the ID/EX pipeline register and consumes the 3-bit ALUControl produced in decode. Each cycle it selects forwarded operands, runs the ALU, and resolves branch/jump redirect. It then registers the results into the EX/MEM register for the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports, in order name / direction / width / meaning:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- FlushE in 1: load a bubble into ID/EX on the next edge.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD in 1 each: decode control.
- ResultSrcD in 2: writeback source select.
- ALUControlD in 3: ALU operation from the decoder.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D in XLEN each: decode data.
- Rs1D, Rs2D, RdD in 5 each: register indices.
- ForwardAE, ForwardBE in 2 each: operand select from the hazard unit.
- ResultW in XLEN: writeback-stage result.
- Rs1E, Rs2E, RdE out 5 each: to the hazard unit.
- ResultSrcE0 out 1: ResultSrcE[0], load-use detect.
- PCSrcE out 1: take redirect.
- PCTargetE out XLEN: redirect target.
- RegWriteM, MemWriteM out 1 each: memory-stage control.
- ResultSrcM out 2: memory-stage writeback select.
- RdM out 5: memory-stage destination register.
- ALUResultM, WriteDataM, PCPlus4M out XLEN each: memory-stage data.

## Operation
- ID/EX register: on each rising edge, all D inputs are captured into E copies.
  - If FlushE=1, every E field loads 0 instead. A zeroed entry has no RegWrite, no MemWrite, no Branch and no Jump, so it is a bubble.
- Operand forwarding:
  - SrcAE: ForwardAE=00 selects RD1E, 01 selects ResultW, 10 selects ALUResultM, 11 is treated as 00.
  - WriteDataE uses the same mux driven by ForwardBE and RD2E.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations, all XLEN-wide with wrap-around and no overflow flag:
  - 000: add.
  - 001: sub.
  - 010: and.
  - 011: or.
  - 101: signed set-less-than; result is 1 when SrcAE < SrcBE as signed, else 0.
  - 100, 110, 111: result 0.
- ZeroE = (ALUResultE == 0).
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
- PCSrcE = (BranchE & ZeroE) | JumpE. This is beq semantics; decode issues sub for branches.
- EX/MEM register: on each rising edge it captures RegWriteE, ResultSrcE, MemWriteE, ALUResultE, WriteDataE (the forwarded value), RdE and PCPlus4E. This register has no flush or stall.

## Timing
- Reset: when rst is low, all ID/EX and EX/MEM fields clear to 0 immediately, without waiting for a clock edge.
  - PCSrcE=0 and PCTargetE=0 while in reset.
  - rst deasserted mid-stream: the first capture happens on the next rising edge.
- Latency: a D-stage value captured at edge N appears on the E outputs after edge N and on the M outputs after edge N+1.
- PCSrcE, PCTargetE and the E-side hazard outputs are combinational from the ID/EX register. The fetch and decode flush logic samples them in the same cycle.
- Simultaneous events:
  - FlushE=1 and rst low: reset dominates.
  - FlushE=1 while the current E entry is a taken branch: the branch still resolves this cycle; the bubble enters at the next edge.
- Forwarding inputs are sampled combinationally in the E cycle. No stall input exists; load-use stalls are created upstream through FlushE.

## Structure
- Shared package, alu_pkg, containing:
  - the ALUControl encoding constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101;
  - the forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- The decoder imports the same package.
- One sub-module, alu: purely combinational, with SrcA, SrcB and ALUControl in, Result and Zero out.
- Pipeline registers, muxes and the target adder stay in execute_stage.

## Test plan
- Reset, then release:
  - Stimulus: drive rst low with random D inputs, then release.
  - Required: all outputs are 0 while reset is asserted, including PCSrcE=0. After release, the first edge captures the D inputs.
- ALU operations:
  - Stimulus: RD1D=7, RD2D=5, ALUSrcD=0, ALUControlD swept over 000, 001, 010, 011, 101.
  - Required: ALUResultM = 12, 2, 5, 7, 0 respectively, each two edges after capture.
  - Stimulus: RD1D=-3, RD2D=2 with slt.
  - Required: ALUResultM=1.
- Branch and jump:
  - Stimulus: BranchD=1, sub, RD1D=RD2D=9, PCD=0x100, ImmExtD=0x20.
  - Required: PCSrcE=1 and PCTargetE=0x120.
  - Stimulus: same with RD2D=8.
  - Required: PCSrcE=0.
  - Stimulus: JumpD=1.
  - Required: PCSrcE=1 regardless of ZeroE.
- Forwarding:
  - Stimulus: ForwardAE=10 with ALUResultM=0x40; ForwardBE=01 with ResultW=0x4; add.
  - Required: ALUResultE=0x44, and WriteDataM=0x4 after the next edge.
  - Stimulus: ForwardAE=11.
  - Required: RD1E is used.
- Flush:
  - Stimulus: FlushE=1 while the D inputs carry RegWriteD=1, MemWriteD=1, JumpD=1.
  - Required: the next E entry is all-zero (PCSrcE=0), and RegWriteM=MemWriteM=0 after the following edge.
- Wrap-around:
  - Stimulus: add with 0xFFFFFFFF + 1.
  - Required: ALUResultM=0 and ZeroE=1.
  - Stimulus: sub 0 - 1.
  - Required: 0xFFFFFFFF.
